tq_quant: RTL and testbench
===========================

TQ_QUANT -- requirements
Module: tq_quant

Interface
REQ-001 SHALL have parameter COEF_W, default 16: signed width of input coefficient and output level.
REQ-002 SHALL have parameter QP_MAX, default 51: highest legal QP; larger inputs are clamped.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 coef_valid_i  input  1  forward transform coefficient valid.
REQ-006 coef_ready_o  output  1  block accepts coefficient this cycle.
REQ-007 coef_i  input  COEF_W  signed coefficient W; 16 per 4x4 block, raster order (row-major).
REQ-008 qp_i  input  6  quantisation parameter; sampled only with the first coefficient of a block.
REQ-009 intra_i  input  1  rounding mode, sampled with qp_i: 1 = intra, 0 = inter.
REQ-010 level_valid_o  output  1  quantised level valid.
REQ-011 level_ready_i  input  1  downstream accepts level.
REQ-012 level_o  output  COEF_W  signed quantised level Z.
REQ-013 level_last_o  output  1  asserted with the 16th level of a block.

Function
REQ-014 Transfer SHALL occur on valid&&ready at each port; level outputs SHALL hold stable while level_valid_o=1 and level_ready_i=0.
REQ-015 Datapath SHALL be a 2-stage pipeline; enable = !level_valid_o || level_ready_i; coef_ready_o = enable (combinational).
REQ-016 Latency SHALL be 2 cycles from accepted coefficient to level_valid_o with no backpressure; throughput 1 per cycle.
REQ-017 A 4-bit position counter SHALL increment per accepted coefficient, wrap 15->0; position 0 marks block start.
REQ-018 At position 0 the block SHALL latch qpc = min(qp_i, QP_MAX), qp_div6 = qpc/6, qp_mod6 = qpc%6 and intra_i; these SHALL stay constant for the other 15 coefficients, whatever qp_i does.
REQ-019 Position class SHALL be: A for (r,c) both even, B for both odd, C otherwise.
REQ-020 MF SHALL come from [qp_mod6][class]: 0:{13107,5243,8066} 1:{11916,4660,7490} 2:{10082,4194,6554} 3:{9362,3647,5825} 4:{8192,3355,5243} 5:{7282,2893,4559}.
REQ-021 Stage 1 SHALL register |W|, sign(W), MF, qbits = 15 + qp_div6, rounding f and a last flag.
REQ-022 Rounding f SHALL be floor(2^qbits/3) for intra and floor(2^qbits/6) for inter.
REQ-023 Stage 2 SHALL compute |Z| = (|W|*MF + f) >> qbits using an unsigned product of at least 32 bits, so the result never overflows.
REQ-024 Stage 2 SHALL then set Z = -|Z| when W < 0, saturate Z to +/-(2^(COEF_W-1)-1), and map a -0 result to 0.
REQ-025 W = -2^(COEF_W-1) SHALL be handled as |W| = 2^(COEF_W-1) without wrap.
REQ-026 level_last_o SHALL travel with the coefficient that was accepted at position 15.
REQ-027 A simultaneous input accept and output drain SHALL lose and duplicate no data.

Reset
REQ-028 When rst_ni=0 at a clock edge, the following SHALL be cleared to 0: level_valid_o, level_o, level_last_o, both pipeline valid flags, the position counter, qpc, qp_div6, qp_mod6 and the intra flag.
REQ-029 Reset mid-block SHALL discard in-flight data; the next accepted coefficient SHALL be position 0.
REQ-030 coef_ready_o SHALL be 1 in the first cycle after reset.

Structure
REQ-031 The MF table, the QBITS_BASE=15 constant and the position-class enum SHALL live in shared package tq_pkg.
REQ-032 The MF lookup plus QP divide/modulo SHALL be one sub-module, tq_mf_lut (combinational; inputs qp, position; outputs MF, qp_div6).

Verification
REQ-033 qp=0, intra, W=1000 at position 0 -> level 400 two cycles later.
REQ-034 qp=28, intra, W=+100 / -100 at position 0 -> level +1 / -1.
REQ-035 qp=60, inter, block of 16 coefficients -> qpc=51 (mod 3, qbits 23); all 16 outputs match a reference model; level_last_o only on the 16th.
REQ-036 qp_i changed at position 5 mid-block -> positions 5..15 still use the latched QP; the new value takes effect from the next position 0.
REQ-037 level_ready_i held low for 5 cycles with a full pipeline -> coef_ready_o=0, level_o stable, no loss or duplication after release.
REQ-038 rst_ni pulsed low at position 7 -> outputs cleared; the following block starts at position 0 with a correct class sequence.

Source files
------------

// File: rtl/tq_pkg.sv
// Shared constants and types for the 4x4 forward quantiser.
package tq_pkg;

  localparam int unsigned QBITS_BASE = 15;
  localparam int unsigned MF_W       = 14;

  // Coefficient position class inside a 4x4 block
  typedef enum logic [1:0] {
    ClassA = 2'd0,  // row and column both even
    ClassB = 2'd1,  // row and column both odd
    ClassC = 2'd2   // mixed parity
  } pos_class_e;

  // Multiplication factor indexed by [qp % 6][class]
  localparam logic [MF_W-1:0] MF_TABLE [6][3] = '{
    '{14'd13107, 14'd5243, 14'd8066},
    '{14'd11916, 14'd4660, 14'd7490},
    '{14'd10082, 14'd4194, 14'd6554},
    '{14'd9362,  14'd3647, 14'd5825},
    '{14'd8192,  14'd3355, 14'd5243},
    '{14'd7282,  14'd2893, 14'd4559}
  };

  // Raster position: pos[3:2] is the row, pos[1:0] the column
  function automatic pos_class_e pos_class(input logic [3:0] pos);
    if (!pos[2] && !pos[0]) return ClassA;
    if (pos[2] && pos[0]) return ClassB;
    return ClassC;
  endfunction

endpackage

// File: rtl/tq_mf_lut.sv
// QP split into qp/6 and qp%6, plus the MF lookup for a block position.
module tq_mf_lut
  import tq_pkg::*;
(
  input  logic [5:0]      qp_i,
  input  logic [3:0]      pos_i,
  output logic [MF_W-1:0] mf_o,
  output logic [3:0]      qp_div6_o,
  output logic [2:0]      qp_mod6_o
);

  logic [2:0] mod6;

  // Divide/modulo by a constant and table read
  always_comb begin
    qp_div6_o = 4'(qp_i / 6'd6);
    mod6      = 3'(qp_i % 6'd6);
    qp_mod6_o = mod6;
    mf_o      = MF_TABLE[mod6][pos_class(pos_i)];
  end

endmodule

// File: rtl/tq_quant.sv
// Two-stage forward quantiser for 4x4 blocks of transform coefficients.
module tq_quant
  import tq_pkg::*;
#(
  parameter int unsigned COEF_W = 16,
  parameter int unsigned QP_MAX = 51
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     coef_valid_i,
  output logic                     coef_ready_o,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic [5:0]               qp_i,
  input  logic                     intra_i,
  output logic                     level_valid_o,
  input  logic                     level_ready_i,
  output logic signed [COEF_W-1:0] level_o,
  output logic                     level_last_o
);

  // Wide enough that |W|*MF + f can never overflow
  localparam int unsigned PROD_W = (COEF_W + MF_W + 2 > 32) ? COEF_W + MF_W + 2 : 32;
  localparam logic [PROD_W-1:0] MAG_MAX = {{(PROD_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};

  logic              enable, accept, blk_start;
  logic [3:0]        pos_q;
  logic [5:0]        qpc_q, qp_clamped, lut_qp;
  logic [3:0]        qp_div6_q, lut_div6, eff_div6;
  logic [2:0]        qp_mod6_q, lut_mod6;
  logic              intra_q, eff_intra;
  logic [MF_W-1:0]   lut_mf;
  logic [COEF_W-1:0] abs_w;
  logic [4:0]        qbits;
  logic [PROD_W-1:0] pow2, f_val;

  logic              s1_valid_q, s1_neg_q, s1_last_q;
  logic [COEF_W-1:0] s1_abs_q;
  logic [MF_W-1:0]   s1_mf_q;
  logic [4:0]        s1_qbits_q;
  logic [PROD_W-1:0] s1_f_q;

  logic [PROD_W-1:0]        prod, mag;
  logic [COEF_W-1:0]        mag_sat;
  logic signed [COEF_W-1:0] level_d;

  // Whole pipeline advances together unless the output is blocked
  assign enable       = !level_valid_o || level_ready_i;
  assign coef_ready_o = enable;
  assign accept       = coef_valid_i && enable;
  assign blk_start    = (pos_q == 4'd0);

  assign qp_clamped = (32'(qp_i) > QP_MAX) ? 6'(QP_MAX) : qp_i;
  // Mid-block the LUT sees the latched QP so qp_i changes are ignored
  assign lut_qp     = blk_start ? qp_clamped : qpc_q;
  assign eff_div6   = blk_start ? lut_div6 : qp_div6_q;
  assign eff_intra  = blk_start ? intra_i : intra_q;

  tq_mf_lut u_mf_lut (
    .qp_i      (lut_qp),
    .pos_i     (pos_q),
    .mf_o      (lut_mf),
    .qp_div6_o (lut_div6),
    .qp_mod6_o (lut_mod6)
  );

  // Stage-1 operand preparation; -2^(COEF_W-1) negates to its own unsigned magnitude
  always_comb begin
    abs_w = coef_i[COEF_W-1] ? $unsigned(-coef_i) : $unsigned(coef_i);
    qbits = 5'(QBITS_BASE) + 5'(eff_div6);
    pow2  = PROD_W'(1) << qbits;
    f_val = eff_intra ? pow2 / PROD_W'(3) : pow2 / PROD_W'(6);
  end

  // Position counter and block parameters latched on the first coefficient
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos_q     <= '0;
      qpc_q     <= '0;
      qp_div6_q <= '0;
      qp_mod6_q <= '0;
      intra_q   <= 1'b0;
    end else if (accept) begin
      pos_q <= pos_q + 4'd1;
      if (blk_start) begin
        qpc_q     <= qp_clamped;
        qp_div6_q <= lut_div6;
        qp_mod6_q <= lut_mod6;
        intra_q   <= intra_i;
      end
    end
  end

  // Latched residue must agree with the one derived from the latched QP
  always_ff @(posedge clk_i) begin
    if (rst_ni && !blk_start) assert (lut_mod6 == qp_mod6_q);
  end

  // Stage 1 register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_abs_q   <= '0;
      s1_mf_q    <= '0;
      s1_qbits_q <= '0;
      s1_f_q     <= '0;
    end else if (enable) begin
      s1_valid_q <= coef_valid_i;
      if (coef_valid_i) begin
        s1_neg_q   <= coef_i[COEF_W-1];
        s1_last_q  <= (pos_q == 4'd15);
        s1_abs_q   <= abs_w;
        s1_mf_q    <= lut_mf;
        s1_qbits_q <= qbits;
        s1_f_q     <= f_val;
      end
    end
  end

  // Stage 2 arithmetic: scale, round, shift, saturate, restore sign
  always_comb begin
    prod    = PROD_W'(s1_abs_q) * PROD_W'(s1_mf_q) + s1_f_q;
    mag     = prod >> s1_qbits_q;
    mag_sat = (mag > MAG_MAX) ? MAG_MAX[COEF_W-1:0] : mag[COEF_W-1:0];
    level_d = s1_neg_q ? -$signed(mag_sat) : $signed(mag_sat);
  end

  // Output register, held while downstream stalls
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_valid_o <= 1'b0;
      level_o       <= '0;
      level_last_o  <= 1'b0;
    end else if (enable) begin
      level_valid_o <= s1_valid_q;
      if (s1_valid_q) begin
        level_o      <= level_d;
        level_last_o <= s1_last_q;
      end
    end
  end

endmodule

// File: tb/tb_tq_quant.sv
// Scoreboard bench for tq_quant with a behavioural quantiser model.
module tb_tq_quant;

  localparam int QP_MAX = 51;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, coef_valid, coef_ready, intra;
  logic               level_valid, level_ready, level_last;
  logic signed [15:0] coef, level;
  logic [5:0]         qp;

  tq_quant #(
    .COEF_W (16),
    .QP_MAX (QP_MAX)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .coef_valid_i  (coef_valid),
    .coef_ready_o  (coef_ready),
    .coef_i        (coef),
    .qp_i          (qp),
    .intra_i       (intra),
    .level_valid_o (level_valid),
    .level_ready_i (level_ready),
    .level_o       (level),
    .level_last_o  (level_last)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_lvl[$];
  bit exp_last[$];

  // Model block state
  int m_pos = 0;
  int m_qp  = 0;
  bit m_intra = 1'b0;

  int mf_tab [6][3] = '{
    '{13107, 5243, 8066}, '{11916, 4660, 7490}, '{10082, 4194, 6554},
    '{9362, 3647, 5825},  '{8192, 3355, 5243},  '{7282, 2893, 4559}
  };

  function automatic int ref_level(int w, int q, bit intr, int pos);
    int r, c, cls, qb;
    longint a, f, m;
    r = pos / 4;
    c = pos % 4;
    if (r % 2 == 0 && c % 2 == 0) cls = 0;
    else if (r % 2 == 1 && c % 2 == 1) cls = 1;
    else cls = 2;
    qb = 15 + q / 6;
    f = (longint'(1) << qb) / (intr ? 3 : 6);
    a = (w < 0) ? -longint'(w) : longint'(w);
    m = (a * mf_tab[q % 6][cls] + f) >> qb;
    if (m > 32767) m = 32767;
    return (w < 0) ? -int'(m) : int'(m);
  endfunction

  function automatic int rand_coef();
    logic signed [15:0] r16;
    r16 = 16'($urandom);
    return int'(r16);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_accept(input int w, input int q, input bit intr);
    if (m_pos == 0) begin
      m_qp    = (q > QP_MAX) ? QP_MAX : q;
      m_intra = intr;
    end
    exp_lvl.push_back(ref_level(w, m_qp, m_intra, m_pos));
    exp_last.push_back(m_pos == 15);
    m_pos = (m_pos + 1) % 16;
  endtask

  // One clock of stimulus; inputs change on the falling edge
  task automatic cycle(input bit v, input int w, input int q, input bit intr, input bit rdy,
                       output bit acc);
    @(negedge clk);
    coef_valid  = v;
    coef        = 16'(w);
    qp          = 6'(q);
    intra       = intr;
    level_ready = rdy;
    #2;
    acc = v && coef_ready;
    if (acc) model_accept(w, q, intr);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n       = 1'b0;
    coef_valid  = 1'b0;
    level_ready = 1'b1;
    exp_lvl.delete();
    exp_last.delete();
    m_pos = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_level_valid", level_valid, 0);
    check("rst_level", level, 0);
    check("rst_level_last", level_last, 0);
    check("rst_coef_ready", coef_ready, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 60 && exp_lvl.size() != 0; i++) cycle(0, 0, 0, 0, 1, acc);
    check("drain_empty", exp_lvl.size(), 0);
  endtask

  // Single coefficient at position 0, level checked exactly two cycles later
  task automatic lat_check(input int w, input int q, input bit intr, input int expv,
                           input string name);
    bit acc;
    reset_dut();
    cycle(1, w, q, intr, 1, acc);
    check({name, "_accept"}, acc, 1);
    cycle(0, 0, 0, 0, 1, acc);
    check({name, "_not_early"}, level_valid, 0);
    @(negedge clk);
    #2;
    check({name, "_valid"}, level_valid, 1);
    check({name, "_level"}, level, expv);
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks stall stability
  bit prev_stall = 1'b0;
  int prev_lvl = 0;
  bit prev_last = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", level_valid, 1);
        check("hold_level", level, prev_lvl);
        check("hold_last", level_last, prev_last);
      end
      if (level_valid && level_ready) begin
        if (exp_lvl.size() == 0) begin
          check("unexpected_level", 1, 0);
        end else begin
          check("level", level, exp_lvl.pop_front());
          check("level_last", level_last, exp_last.pop_front());
        end
      end
      prev_stall = level_valid && !level_ready;
      prev_lvl   = level;
      prev_last  = level_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int w, sent, guard;
    rst_n = 1'b0; coef_valid = 1'b0; coef = '0; qp = '0; intra = 1'b0; level_ready = 1'b1;
    reset_dut();

    lat_check(1000, 0, 1, 400, "qp0_intra");
    lat_check(100, 28, 1, 1, "qp28_pos");
    lat_check(-100, 28, 1, -1, "qp28_neg");

    // QP above the limit, inter rounding, extreme coefficients
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      w = (i == 3) ? -32768 : (i == 9) ? 32767 : rand_coef();
      cycle(1, w, 60, 0, 1, acc);
    end
    drain();

    // QP changes mid-block; new value only from the next block start
    for (int i = 0; i < 32; i++) cycle(1, rand_coef(), (i < 5) ? 10 : 40, 1, 1, acc);
    drain();

    // Backpressure with a full pipeline
    reset_dut();
    cycle(1, rand_coef(), 20, 1, 0, acc);
    cycle(1, rand_coef(), 20, 1, 0, acc);
    w = rand_coef();
    for (int i = 0; i < 5; i++) begin
      cycle(1, w, 20, 1, 0, acc);
      check("stall_coef_ready", coef_ready, 0);
    end
    cycle(1, w, 20, 1, 1, acc);
    check("release_accept", acc, 1);
    for (int i = 3; i < 16; i++) cycle(1, rand_coef(), 20, 1, 1, acc);
    drain();

    // Reset at position 7, then a fresh block under random backpressure
    reset_dut();
    for (int i = 0; i < 7; i++) cycle(1, rand_coef(), 37, 0, 1, acc);
    reset_dut();
    sent = 0;
    guard = 0;
    while (sent < 16 && guard < 200) begin
      cycle(1, rand_coef(), 33, 1, $urandom_range(0, 2) != 0, acc);
      if (acc) sent++;
      guard++;
    end
    check("post_reset_block_sent", sent, 16);
    drain();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) reset_dut();
      case ($urandom_range(0, 7))
        0: w = -32768;
        1: w = 32767;
        2: w = $urandom_range(0, 40) - 20;
        default: w = rand_coef();
      endcase
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 63), $urandom_range(0, 1),
            $urandom_range(0, 3) != 0, acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
